motoro3_pwm_ramp_scheduler: RTL and testbench
=============================================

# motoro3_pwm_ramp_scheduler

Duty-cycle sequencer for the 3-phase motor PWM path. It takes a requested duty from the control side and ramps the PWM generator's duty input toward it in bounded steps. Every duty change is aligned to the commutation-period boundary pulse `m3cntLast1`. It enforces the minimum MOSFET on-time, forces the output off on a fault, and latches the fault until it is explicitly cleared. It sits between the speed/command logic and the PWM generator, driving its `pwmLenWant` and `pwmMinMask` inputs.

## Interface
Parameters:
- `MIN_DUTY`, 8'h20: smallest non-zero duty that may be issued (3.2 us on-time at 10 MHz).
- `RAMP_STEP`, 8'd4: duty increment or decrement per ramp step.
- `RAMP_DIV`, 4: number of `m3cntLast1` boundaries per ramp step (1..15).
- `WDOG_CYCLES`, 24'd1_000_000: watchdog timeout in clk cycles.

Ports:
- `clk`, in, 1: 10 MHz system clock; all logic on posedge.
- `nRst`, in, 1: reset, asynchronous, active-low.
- `dutyTarget`, in, 8: requested duty; sampled only when `dutyLoad` is 1.
- `dutyLoad`, in, 1: one-cycle strobe that latches `dutyTarget`.
- `m3cntLast1`, in, 1: one-cycle commutation-period boundary pulse.
- `faultIn`, in, 1: external fault (overcurrent), level.
- `faultClr`, in, 1: one-cycle fault-clear strobe.
- `pwmLenWant`, out, 8: duty issued to the PWM generator.
- `pwmMinMask`, out, 8: minimum-duty mask issued to the PWM generator.
- `rampBusy`, out, 1: 1 while in RAMP.
- `faultLatched`, out, 1: 1 while in FAULT.
- `faultCause`, out, 2: bit0 = external fault, bit1 = watchdog; sticky until cleared.
- `state`, out, 2: IDLE=0, RAMP=1, HOLD=2, FAULT=3.

## Operation
- Registers:
  - `tgt`: target duty, 8 bits.
  - `cur`: drives `pwmLenWant`.
  - `divCnt`: boundary counter, 4 bits.
- `dutyTarget` below `MIN_DUTY` is latched as `tgt`=0.
- IDLE:
  - `cur`=0, `pwmMinMask`=0.
  - `dutyLoad` with an effective target of 0 or more → `tgt` latched; non-zero target → RAMP with `divCnt`=0.
- RAMP:
  - On the first boundary after entry from IDLE, `cur`=`MIN_DUTY`; this is a jump, not a step.
  - After that, each boundary increments `divCnt`.
  - When `divCnt` = `RAMP_DIV`-1: `divCnt`=0 and `cur` moves toward `tgt` by `RAMP_STEP`.
    - Saturating 9-bit arithmetic, clamped to `tgt`; never overshoots, never wraps past 8'hFF or 0.
  - Ramping down to `tgt`=0: once a step would bring `cur` below `MIN_DUTY`, `cur`=0 and the state goes to IDLE.
  - `cur` == `tgt` (non-zero) → HOLD.
- HOLD:
  - `cur` is held.
  - `dutyLoad` with a different effective target → RAMP, `divCnt`=0, stepping from the present `cur`.
  - Same target → no change.
- `pwmMinMask` = `MIN_DUTY` in RAMP and HOLD, 0 otherwise.
- FAULT:
  - Entered from any state when `faultIn`=1.
  - `cur`=0, `tgt`=0, `pwmMinMask`=0 in the next clk, not boundary-aligned.
  - `faultCause` bits are OR-accumulated.
  - `faultClr`=1 while `faultIn`=0 → IDLE, `faultCause`=0.
  - `dutyLoad` is ignored in FAULT.
- Simultaneous events:
  - `faultIn` beats every other input, including `faultClr`.
  - `dutyLoad` in the same cycle as a ramp-step boundary: the step uses the old `tgt`; the new `tgt` applies from the next boundary.
  - `dutyLoad` in the same cycle as the IDLE→RAMP entry boundary: the load is latched; the entry jump still happens.
- Reset mid-operation: everything returns to its reset value immediately, asynchronously.

## Timing
- Reset values:
  - `pwmLenWant`=0, `pwmMinMask`=0, `rampBusy`=0, `faultLatched`=0, `faultCause`=0, `state`=IDLE.
  - Internal: `tgt`=0, `divCnt`=0, watchdog counter=0.
- All outputs are registered.
- `pwmLenWant` changes in the clk after the `m3cntLast1` cycle. The PWM generator therefore picks up the value at the following boundary, one full period later.
- `dutyLoad` → `tgt` updated the next clk. It affects `cur` no earlier than the next boundary.
- `faultIn` → `pwmLenWant`=0 and `state`=FAULT after 1 clk.
- `faultClr` → IDLE after 1 clk.

## Configuration
- `MOTORO3_RAMP_WATCHDOG_EN` defined:
  - A 24-bit counter runs only in RAMP and HOLD.
  - It clears on `m3cntLast1` and on every state change.
  - At `WDOG_CYCLES`-1 the block enters FAULT with `faultCause[1]`=1.
- Undefined:
  - No counter is built.
  - `faultCause[1]` is tied to 0.
  - Rotor stall is not detected.

## Test plan
- Reset with all inputs 0, boundary every 100 clk → all outputs 0, `state`=0 for 1000 clk.
- `dutyLoad` with `dutyTarget`=8'h40:
  - `pwmLenWant` = 8'h20 one clk after the next boundary.
  - Then 8'h24, 8'h28 … 8'h40, one step every 4 boundaries, 8 steps in all.
  - `state`=HOLD at 8'h40.
- In HOLD at 8'h40, load 8'h10 (below minimum, so target 0):
  - Ramp down 8'h3C … 8'h20 every 4 boundaries.
  - Next step gives 0 and `state`=IDLE.
- During RAMP at 8'h30, assert `faultIn`:
  - `pwmLenWant`=0 and `faultLatched`=1 after 1 clk; `faultCause`=2'b01.
  - `faultClr` with `faultIn` still 1 → no exit.
  - Drop `faultIn`, then `faultClr` → IDLE.
- Load 8'hFE then 8'hFF from HOLD at 8'hFC → steps clamp at 8'hFE, then 8'hFF; no wrap to 0.
- With `MOTORO3_RAMP_WATCHDOG_EN` defined and `WDOG_CYCLES`=1000, reach HOLD then stop `m3cntLast1` → FAULT with `faultCause`=2'b10, 1000 clk after the last boundary.

Source files
------------

// File: rtl/motoro3_pwm_ramp_scheduler.sv
// motoro3_pwm_ramp_scheduler
// Ramps the PWM duty request toward a commanded target in bounded steps,
// aligned to the commutation boundary pulse m3cntLast1. Enforces the minimum
// on-time, forces the output off on a fault and latches the fault until it
// is cleared.
// Optional feature: define MOTORO3_RAMP_WATCHDOG_EN to build the stall
// watchdog, which faults when no boundary arrives for WDOG_CYCLES clocks.
`timescale 1ns/1ps
module motoro3_pwm_ramp_scheduler #(
    parameter logic [7:0]  MIN_DUTY    = 8'h20,
    parameter logic [7:0]  RAMP_STEP   = 8'd4,
    parameter int unsigned RAMP_DIV    = 4,
    parameter logic [23:0] WDOG_CYCLES = 24'd1_000_000
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [7:0] dutyTarget,
    input  logic       dutyLoad,
    input  logic       m3cntLast1,
    input  logic       faultIn,
    input  logic       faultClr,
    output logic [7:0] pwmLenWant,
    output logic [7:0] pwmMinMask,
    output logic       rampBusy,
    output logic       faultLatched,
    output logic [1:0] faultCause,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [3:0] DIV_LAST = 4'(RAMP_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] tgt_q, tgt_d;
    logic [7:0] cur_q, cur_d;
    logic [3:0] divCnt_q, divCnt_d;
    logic       first_q, first_d;   // entry jump to MIN_DUTY still pending
    logic [1:0] cause_q, cause_d;
    logic [7:0] mask_q;
    logic       busy_q, flt_q;

    logic [7:0] effTgt;
    logic [8:0] upSum, dnDiff;
    logic [7:0] stepVal;
    logic       stepToZero;
    logic       wdogTrip;

    assign effTgt = (dutyTarget < MIN_DUTY) ? '0 : dutyTarget;

    // One ramp step from cur toward tgt: 9-bit saturating, clamped to tgt
    always_comb begin
        upSum      = {1'b0, cur_q} + {1'b0, RAMP_STEP};
        dnDiff     = {1'b0, cur_q} - {1'b0, RAMP_STEP};
        stepVal    = cur_q;
        stepToZero = 1'b0;
        if (tgt_q > cur_q) begin
            stepVal = (upSum > {1'b0, tgt_q}) ? tgt_q : upSum[7:0];
        end else if (tgt_q == '0) begin
            stepToZero = dnDiff[8] || (dnDiff[7:0] < MIN_DUTY);
            stepVal    = stepToZero ? '0 : dnDiff[7:0];
        end else begin
            stepVal = (dnDiff[8] || (dnDiff[7:0] < tgt_q)) ? tgt_q : dnDiff[7:0];
        end
    end

    // Next-state and datapath decisions; faults take priority over everything
    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        cur_d    = cur_q;
        divCnt_d = divCnt_q;
        first_d  = first_q;
        cause_d  = cause_q;
        if (faultIn || wdogTrip) begin
            state_d  = FAULT;
            cur_d    = '0;
            tgt_d    = '0;
            divCnt_d = '0;
            first_d  = 1'b0;
            cause_d  = cause_q | {wdogTrip, faultIn};
        end else begin
            unique case (state_q)
                IDLE: begin
                    cur_d = '0;
                    if (dutyLoad) begin
                        tgt_d = effTgt;
                        if (effTgt != '0) begin
                            state_d  = RAMP;
                            divCnt_d = '0;
                            first_d  = 1'b1;
                        end
                    end
                end
                RAMP: begin
                    // A load lands in tgt_d only; the step below still uses tgt_q
                    if (dutyLoad) tgt_d = effTgt;
                    if (first_q) begin
                        if (m3cntLast1) begin
                            cur_d   = MIN_DUTY;
                            first_d = 1'b0;
                        end else if (tgt_q == '0) begin
                            state_d = IDLE;
                            first_d = 1'b0;
                        end
                    end else if (m3cntLast1) begin
                        if (divCnt_q == DIV_LAST) begin
                            divCnt_d = '0;
                            cur_d    = stepVal;
                            if (stepToZero) state_d = IDLE;
                        end else begin
                            divCnt_d = divCnt_q + 4'd1;
                        end
                    end
                    // Compare against the post-load target so a coincident load is not lost
                    if (state_d == RAMP && !first_d && cur_d == tgt_d && tgt_d != '0)
                        state_d = HOLD;
                end
                HOLD: begin
                    if (dutyLoad && effTgt != tgt_q) begin
                        tgt_d    = effTgt;
                        state_d  = RAMP;
                        divCnt_d = '0;
                        first_d  = 1'b0;
                    end
                end
                FAULT: begin
                    cur_d = '0;
                    tgt_d = '0;
                    if (faultClr) begin
                        state_d = IDLE;
                        cause_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, datapath and registered output flags
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= IDLE;
            tgt_q    <= '0;
            cur_q    <= '0;
            divCnt_q <= '0;
            first_q  <= 1'b0;
            cause_q  <= '0;
            mask_q   <= '0;
            busy_q   <= 1'b0;
            flt_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            cur_q    <= cur_d;
            divCnt_q <= divCnt_d;
            first_q  <= first_d;
            cause_q  <= cause_d;
            mask_q   <= (state_d == RAMP || state_d == HOLD) ? MIN_DUTY : '0;
            busy_q   <= (state_d == RAMP);
            flt_q    <= (state_d == FAULT);
        end
    end

`ifdef MOTORO3_RAMP_WATCHDOG_EN
    logic [23:0] wdog_q, wdog_d;
    logic        wdogActive;

    assign wdogActive = (state_q == RAMP) || (state_q == HOLD);
    assign wdogTrip   = wdogActive && (wdog_q == WDOG_CYCLES - 24'd1);

    // Stall counter: runs in RAMP/HOLD, restarts on each boundary and state change
    always_comb begin
        wdog_d = '0;
        if (wdogActive && !m3cntLast1 && (state_d == state_q))
            wdog_d = wdog_q + 24'd1;
    end

    // Stall counter register
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) wdog_q <= '0;
        else       wdog_q <= wdog_d;
    end
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_CYCLES;
    assign wdogTrip    = 1'b0;
`endif

    assign pwmLenWant   = cur_q;
    assign pwmMinMask   = mask_q;
    assign rampBusy     = busy_q;
    assign faultLatched = flt_q;
    assign faultCause   = cause_q;
    assign state        = state_q;

endmodule

// File: tb/tb_motoro3_pwm_ramp_scheduler.sv
// Scoreboard bench for motoro3_pwm_ramp_scheduler: the stimulus side predicts
// every output change from the ramp rules and queues it; a monitor pops and
// compares whenever the observed outputs change.
`timescale 1ns/1ps
module tb_motoro3_pwm_ramp_scheduler;

    localparam int MIN  = 32;
    localparam int STEP = 4;
    localparam int DIV  = 4;
    localparam int WDOG = 1000;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic [7:0] dutyTarget = '0;
    logic       dutyLoad = 1'b0, m3cntLast1 = 1'b0, faultIn = 1'b0, faultClr = 1'b0;
    logic [7:0] pwmLenWant, pwmMinMask;
    logic       rampBusy, faultLatched;
    logic [1:0] faultCause, state;

    motoro3_pwm_ramp_scheduler #(
        .MIN_DUTY   (8'(MIN)),
        .RAMP_STEP  (8'(STEP)),
        .RAMP_DIV   (DIV),
        .WDOG_CYCLES(24'(WDOG))
    ) dut (
        .clk         (clk),
        .nRst        (nRst),
        .dutyTarget  (dutyTarget),
        .dutyLoad    (dutyLoad),
        .m3cntLast1  (m3cntLast1),
        .faultIn     (faultIn),
        .faultClr    (faultClr),
        .pwmLenWant  (pwmLenWant),
        .pwmMinMask  (pwmMinMask),
        .rampBusy    (rampBusy),
        .faultLatched(faultLatched),
        .faultCause  (faultCause),
        .state       (state)
    );

    always #50 clk = ~clk;

    typedef struct {
        int    st;
        int    duty;
        int    cause;
        int    bidx;   // >=0: change due 1 clk after that boundary
        int    cyc;    // used when bidx < 0
        string tag;
    } exp_t;

    exp_t sb[$];
    int   bnd_at[int];
    int   cyc = 0, bcount = 0, last_issue = 0;
    int   tests = 0, fails = 0;
    int   period = 8;
    int   cur_m = 0, st_m = 0;
    bit   fault_lvl = 1'b0;
    bit   mon_en = 1'b0;
    bit   seeded = 1'b0;
    logic [21:0] prev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every observed output change must match the next queued expectation
    always @(negedge clk) begin
        logic [21:0] obs;
        exp_t        e;
        int          ecyc;
        obs = {state, pwmLenWant, pwmMinMask, rampBusy, faultLatched, faultCause};
        if (!mon_en) begin
            seeded = 1'b0;
        end else if (!seeded) begin
            prev   = obs;
            seeded = 1'b1;
        end else if (obs !== prev) begin
            prev = obs;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_change: state=%0d duty=%0h cause=%0b at cycle %0d, expected no change",
                         state, pwmLenWant, faultCause, cyc);
            end else begin
                e = sb.pop_front();
                if (e.bidx >= 0) ecyc = bnd_at.exists(e.bidx) ? bnd_at[e.bidx] + 1 : -1;
                else             ecyc = e.cyc;
                check({e.tag, "_state"}, 32'(state), e.st);
                check({e.tag, "_duty"},  32'(pwmLenWant), e.duty);
                check({e.tag, "_mask"},  32'(pwmMinMask), (e.st == 1 || e.st == 2) ? MIN : 0);
                check({e.tag, "_busy"},  32'(rampBusy), (e.st == 1) ? 1 : 0);
                check({e.tag, "_fltl"},  32'(faultLatched), (e.st == 3) ? 1 : 0);
                check({e.tag, "_cause"}, 32'(faultCause), e.cause);
                check({e.tag, "_cycle"}, cyc, ecyc);
            end
        end
    end

    initial begin
        #(100 * 95000);
        $display("FAIL global_timeout: simulation still running, expected to finish");
        $fatal(1, "timeout");
    end

    // ---------------- reference model (ramp rules in plain arithmetic) -------------
    function automatic int eff(input int d);
        return (d < MIN) ? 0 : d;
    endfunction

    function automatic int step_val(input int c, input int t);
        if (t > c)  return (c + STEP > t) ? t : c + STEP;
        if (t == 0) return (c - STEP < MIN) ? 0 : c - STEP;
        return (c - STEP < t) ? t : c - STEP;
    endfunction

    function automatic int st_after(input int v, input int t);
        if (v == 0) return 0;
        if (v == t) return 2;
        return 1;
    endfunction

    task automatic push(input int st, input int duty, input int cause, input int bidx,
                        input int cy, input string tag);
        exp_t e;
        e.st = st; e.duty = duty; e.cause = cause; e.bidx = bidx; e.cyc = cy; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic walk(input int t, input int first_b);
        int c, b;
        c = cur_m;
        b = first_b;
        while (c != t) begin
            c = step_val(c, t);
            push(st_after(c, t), c, 0, b, -1, "step");
            b += DIV;
        end
        cur_m = c;
        st_m  = (c == 0) ? 0 : 2;
    endtask

    // ---------------- stimulus ----------------
    task automatic drv(input bit bnd, input bit ld, input logic [7:0] d, input bit fc);
        @(negedge clk);
        m3cntLast1 = bnd;
        dutyLoad   = ld;
        dutyTarget = ld ? d : 8'($urandom_range(0, 255));
        faultClr   = fc;
        faultIn    = fault_lvl;
        last_issue = cyc;
        if (bnd) begin
            bcount++;
            bnd_at[bcount] = cyc;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic run_period();
        idle(period - 1);
        drv(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            run_period();
            n++;
        end
        idle(2);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL settle_timeout: %0d events pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_load(input int d);
        int e;
        e = eff(d);
        drv(1'b0, 1'b1, 8'(d), 1'b0);
        if (st_m == 0) begin
            if (e != 0) begin
                push(1, 0, 0, -1, last_issue + 1, "load_idle");
                cur_m = MIN;
                push(st_after(MIN, e), MIN, 0, bcount + 1, -1, "entry");
                walk(e, bcount + 1 + DIV);
            end
        end else if (st_m == 2 && e != cur_m) begin
            push(1, cur_m, 0, -1, last_issue + 1, "load_hold");
            walk(e, bcount + DIV);
        end
    endtask

    task automatic do_fault();
        fault_lvl = 1'b1;
        drv(1'b0, 1'b0, 8'h00, 1'b0);
        push(3, 0, 1, -1, last_issue + 1, "fault");
        idle($urandom_range(1, 5));
        drv(1'b1, 1'b1, 8'h80, 1'b1);   // boundary, load and clear all while faulted
        idle(3);
        fault_lvl = 1'b0;
        idle(2);
        drv(1'b0, 1'b0, 8'h00, 1'b1);
        push(0, 0, 0, -1, last_issue + 1, "clear");
        idle(3);
        cur_m = 0;
        st_m  = 0;
    endtask

    initial begin
        int b0, n, d, r;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_duty", 32'(pwmLenWant), 0);
        check("rst_mask", 32'(pwmMinMask), 0);
        check("rst_state", 32'(state), 0);
        check("rst_flags", 32'({rampBusy, faultLatched, faultCause}), 0);
        nRst = 1'b1;
        mon_en = 1'b1;

        // Idle with slow boundaries: nothing may move
        period = 100;
        repeat (10) run_period();
        check("idle_state", 32'(state), 0);
        check("idle_duty", 32'(pwmLenWant), 0);
        period = 8;

        // Ramp up to 0x40, then down to zero via a sub-minimum target
        do_load(8'h40); settle();
        check("hold40_state", 32'(state), 2);
        check("hold40_duty", 32'(pwmLenWant), 8'h40);
        do_load(8'h10); settle();
        check("down_idle_state", 32'(state), 0);

        // Load coincident with the entry boundary: jump still happens, new target kept
        drv(1'b0, 1'b1, 8'h40, 1'b0);
        push(1, 0, 0, -1, last_issue + 1, "co_load");
        b0 = bcount + 1;
        push(1, 8'h20, 0, b0, -1, "co_entry");
        push(1, 8'h24, 0, b0 + DIV, -1, "co_step1");
        push(2, 8'h28, 0, b0 + 2 * DIV, -1, "co_step2");
        idle(period - 1);
        drv(1'b1, 1'b1, 8'h28, 1'b0);
        settle();
        cur_m = 8'h28; st_m = 2;

        // Load coincident with a step boundary: that step uses the old target
        do_load(8'h40); settle();
        drv(1'b0, 1'b1, 8'h60, 1'b0);
        push(1, 8'h40, 0, -1, last_issue + 1, "mid_load");
        b0 = bcount + DIV;
        push(1, 8'h44, 0, b0, -1, "mid_step1");
        push(1, 8'h48, 0, b0 + DIV, -1, "mid_step2");
        push(2, 8'h46, 0, b0 + 2 * DIV, -1, "mid_step3");
        while (bcount < b0 + DIV - 1) run_period();
        idle(period - 1);
        drv(1'b1, 1'b1, 8'h46, 1'b0);
        settle();
        cur_m = 8'h46; st_m = 2;

        // Top-end clamping: no overshoot, no wrap
        do_load(8'hFC); settle();
        do_load(8'hFE); settle();
        do_load(8'hFF); settle();
        check("clamp_ff_duty", 32'(pwmLenWant), 8'hFF);
        do_load(8'h00); settle();

        // Fault mid-ramp at 0x30
        do_load(8'h40);
        n = 0;
        while (pwmLenWant != 8'h30 && n < 100) begin run_period(); n++; end
        check("reach_30", 32'(pwmLenWant), 8'h30);
        idle(2);
        sb.delete();
        do_fault();

        // Randomized loads with occasional faults
        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(0, 5);
            if (r == 0)      d = cur_m;
            else if (r == 1) d = $urandom_range(0, MIN - 1);
            else             d = $urandom_range(0, 255);
            do_load(d);
            settle();
            if ($urandom_range(0, 3) == 0) do_fault();
        end

        // Stall behaviour with boundaries stopped in HOLD
        do_load(8'h60); settle();
`ifdef MOTORO3_RAMP_WATCHDOG_EN
        push(3, 0, 2, -1, bnd_at[bcount] + WDOG + 1, "wdog");
        idle(WDOG + 20);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL wdog_timeout: %0d events pending, expected 0", sb.size());
            sb.delete();
        end
        drv(1'b0, 1'b0, 8'h00, 1'b1);
        push(0, 0, 0, -1, last_issue + 1, "wdog_clear");
        idle(3);
        cur_m = 0; st_m = 0;
`else
        idle(1200);
        check("nowdog_state", 32'(state), 2);
        check("nowdog_cause", 32'(faultCause), 0);
`endif

        // Asynchronous reset in the middle of a clock phase
        do_load(8'h40); settle();
        mon_en = 1'b0;
        @(negedge clk);
        #10 nRst = 1'b0;
        #1;
        check("arst_duty", 32'(pwmLenWant), 0);
        check("arst_state", 32'(state), 0);
        check("arst_mask", 32'(pwmMinMask), 0);
        check("arst_busy", 32'(rampBusy), 0);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
